// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM encoding, mode constants and
// the counter-width helper.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of each digit slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_digit.sv
// DIGIT-bit ripple-carry slice built from full_adder cells. Also exposes the
// carry into its top bit so the caller can derive signed overflow.
module rca_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    full_adder u_fa (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (c[gi]),
      .s    (sum[gi]),
      .cout (c[gi+1])
    );
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, behind a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  import adder_pkg::*;

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, s_reg;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg, cout_reg, ovf_reg, done_reg;
  logic             accept, last;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;

  // One slice handles the current low digit of both operand shift registers.
  rca_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_reg[DIGIT-1:0]),
    .b        (b_reg[DIGIT-1:0]),
    .cin      (carry_reg),
    .sum      (dig_sum),
    .cout     (dig_cout),
    .c_msb_in (dig_cmsb)
  );

  // New digits enter at the top so after NDIG shifts the result is aligned.
  if (DIGIT == WIDTH) begin : g_res_full
    assign res_next = dig_sum;
  end else begin : g_res_shift
    assign res_next = {dig_sum, res_reg[WIDTH-1:DIGIT]};
  end

  // Next-state logic: accept start only in IDLE, leave RUN after the last digit.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (cnt_reg == LAST) begin
          state_next = IDLE;
          last       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: capture operands on accept, shift one digit per RUN cycle,
  // publish the result and flags on the final digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last;
      if (accept) begin
        a_reg     <= a;
        // Subtraction is a + ~b + 1: invert b and force the initial carry.
        b_reg     <= (sub == MODE_SUB) ? ~b : b;
        carry_reg <= (sub == MODE_SUB) ? 1'b1 : cin;
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> DIGIT;
        b_reg     <= b_reg >> DIGIT;
        res_reg   <= res_next;
        carry_reg <= dig_cout;
        cnt_reg   <= cnt_reg + 1'b1;
        if (last) begin
          s_reg    <= res_next;
          cout_reg <= dig_cout;
          ovf_reg  <= dig_cmsb ^ dig_cout;
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign s    = s_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
